pipe_stage_elastic: RTL and testbench
=====================================

// Module: pipe_stage_elastic
// PURPOSE
//   Parametrised elastic pipeline register. It replaces the hand-written per-stage flop banks between PF/IF/ID/EX/MEM/WB.
//   - Payload is a packed bus of width DATA_W.
//   - Upstream and downstream use valid/ready handshakes.
//   - Flush is synchronous.
//   - Exception merge: upstream exceptions take priority over exceptions detected locally in the stage.
//   - A saturating stall counter supports performance analysis.
// PARAMETERS
//   DATA_W    64              payload width in bits (1..512)
//   FLUSH_VAL {DATA_W{1'b0}}  payload value loaded on reset and on flush
//   CNT_W     16              width of the stall counter
//   EXC_NONE  5'd15           ExcCode reported when no exception is pending
// PORTS
//   clk           in   1       rising-edge clock
//   rst           in   1       asynchronous reset, active-low
//   flush         in   1       synchronous flush; kills every held entry
//   in_valid      in   1       upstream entry valid
//   in_ready      out  1       stage can accept an entry this cycle
//   in_data       in   DATA_W  upstream payload
//   in_exc        in   1       upstream exception flag
//   in_exccode    in   5       upstream ExcCode
//   in_badvaddr   in   32      upstream BadVAddr
//   loc_exc       in   1       exception detected in this stage (Ov, AdEL, AdES, ...)
//   loc_exccode   in   5       local ExcCode
//   loc_badvaddr  in   32      local BadVAddr
//   out_valid     out  1       downstream entry valid
//   out_ready     in   1       downstream accepts
//   out_data      out  DATA_W  registered payload
//   out_exc       out  1       merged exception flag
//   out_exccode   out  5       merged ExcCode
//   out_badvaddr  out  32      merged BadVAddr
//   stall_cnt     out  CNT_W   cycles with out_valid && !out_ready; saturates at all-ones
// BEHAVIOUR
//   - Reset: one clock, clk. rst is asynchronous and active-low; all flops use posedge clk / negedge rst.
//     Reset values: out_valid=0, out_data=FLUSH_VAL, out_exc=0, out_exccode=EXC_NONE, out_badvaddr=0, stall_cnt=0, skid empty.
//     Reset mid-transfer drops the entry with no partial state.
//   - Transfers: accept = in_valid && in_ready; issue = out_valid && out_ready. Latency from in to out is 1 cycle.
//   - Exception merge, evaluated on accept:
//     - in_exc=1 -> upstream code and badvaddr are kept.
//     - else loc_exc=1 -> out_exc=1, local code and badvaddr.
//     - else out_exc=0, out_exccode=EXC_NONE, out_badvaddr=0.
//     - Exception fields travel with the entry and are cleared by flush.
//   - Flush has priority over every other event. In the flush cycle:
//     - accept is ignored and the entry is not captured;
//     - the next state is out_valid=0, skid empty, payload=FLUSH_VAL, out_exccode=EXC_NONE;
//     - stall_cnt is not cleared.
//   - Without the skid buffer: in_ready = !out_valid || out_ready (combinational).
//     A simultaneous issue and accept replaces the held entry with no bubble.
//   - stall_cnt increments on each cycle with out_valid && !out_ready && !flush. It holds at all-ones.
//   - out_* must stay stable while out_valid && !out_ready. Both the bench and assertions check this.
// CONFIGURATION
//   Macro PIPE_STAGE_SKID_EN.
//   - Defined: a 1-entry skid buffer is added and in_ready = !skid_valid, driven from a flop with no combinational path from out_ready.
//     - Accept while out_valid && !out_ready: the entry goes to the skid buffer.
//     - Next issue: the skid entry moves to the output.
//     - Throughput is 1 entry/cycle with 2 entries of capacity.
//   - Undefined: no skid storage and a single entry of capacity, with in_ready as above.
//   The port list is identical in both builds.
// STRUCTURE
//   - Shared package pipe_pkg:
//     - EXC_NONE and the ExcCode constants Ov, AdEL, AdES;
//     - a typedef for the exception bundle {exc, exccode[4:0], badvaddr[31:0]};
//     - the merge function exc_merge(in_bundle, loc_bundle).
//   - One sub-module, pipe_stage_slot: a payload plus exception register with load/clear.
//     It is instantiated once for the output and once for the skid buffer when PIPE_STAGE_SKID_EN is defined.
// TESTING
//   1. Stream, DATA_W=64, out_ready=1: send 100 back-to-back entries (0,1,2,...) -> same sequence out, 1-cycle latency, no bubbles, stall_cnt=0.
//   2. Backpressure, out_ready=0 for 5 cycles with entry 0xA5: out_data holds 0xA5 and stall_cnt=5.
//      - No skid: in_ready=0 for the whole window.
//      - Skid: one further entry 0x5A is accepted, then in_ready=0; order after release is 0xA5, 0x5A.
//   3. Exception merge, all in one accept:
//      - in_exc=1/code=4/badvaddr=0x1000 with loc_exc=1/code=12 -> out code=4, badvaddr=0x1000.
//      - in_exc=0, loc_exc=1/code=12/badvaddr=0x2002 -> out_exc=1, code=12.
//      - Neither -> out_exc=0, code=15, badvaddr=0.
//   4. Flush while full (skid full when enabled) with in_valid=1 in the same cycle:
//      - next cycle out_valid=0, out_data=FLUSH_VAL, code=15;
//      - the input entry is not captured and stall_cnt is unchanged.
//   5. Asynchronous reset asserted mid-cycle while out_valid=1:
//      - outputs reach reset values immediately, without a clock edge;
//      - first accept after release completes normally.
//   6. CNT_W=4: hold a stall for 20 cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stages: ExcCodes, the exception bundle
// and the priority merge between upstream and locally detected exceptions.
package pipe_pkg;

    localparam logic [4:0] EXC_NONE = 5'd15;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef struct packed {
        logic        exc;
        logic [4:0]  exccode;
        logic [31:0] badvaddr;
    } exc_t;

    // Upstream exceptions are older in program order, so they win over local ones.
    function automatic exc_t exc_merge(input exc_t in_bundle, input exc_t loc_bundle);
        exc_t res;
        if (in_bundle.exc) begin
            res = in_bundle;
        end else if (loc_bundle.exc) begin
            res = loc_bundle;
        end else begin
            res.exc      = 1'b0;
            res.exccode  = EXC_NONE;
            res.badvaddr = 32'h0;
        end
        return res;
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One storage entry of an elastic stage: payload plus exception bundle.
// clear (flush) has priority over load.
module pipe_stage_slot #(
    parameter int unsigned       DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter logic [4:0]        NONE_CODE = 5'd15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                load,
    input  logic [DATA_W-1:0]   d_data,
    input  pipe_pkg::exc_t      d_exc,
    output logic [DATA_W-1:0]   q_data,
    output pipe_pkg::exc_t      q_exc
);
    import pipe_pkg::*;

    logic [DATA_W-1:0] data_d, data_q;
    exc_t              exc_d, exc_q;
    exc_t              exc_clr;

    assign exc_clr = '{exc: 1'b0, exccode: NONE_CODE, badvaddr: 32'h0};

    // Next-state: clear to the flush image, else load, else hold.
    always_comb begin
        data_d = data_q;
        exc_d  = exc_q;
        if (clear) begin
            data_d = FLUSH_VAL;
            exc_d  = exc_clr;
        end else if (load) begin
            data_d = d_data;
            exc_d  = d_exc;
        end
    end

    // Entry storage with asynchronous reset to the flush image.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= FLUSH_VAL;
            exc_q  <= exc_clr;
        end else begin
            data_q <= data_d;
            exc_q  <= exc_d;
        end
    end

    assign q_data = data_q;
    assign q_exc  = exc_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with valid/ready handshakes, synchronous flush,
// exception merge and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a 1-entry skid buffer that registers in_ready.
module pipe_stage_elastic #(
    parameter int unsigned       DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int unsigned       CNT_W     = 16,
    parameter logic [4:0]        EXC_NONE  = pipe_pkg::EXC_NONE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_exc,
    input  logic [4:0]        in_exccode,
    input  logic [31:0]       in_badvaddr,
    input  logic              loc_exc,
    input  logic [4:0]        loc_exccode,
    input  logic [31:0]       loc_badvaddr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_exc,
    output logic [4:0]        out_exccode,
    output logic [31:0]       out_badvaddr,
    output logic [CNT_W-1:0]  stall_cnt
);
    import pipe_pkg::*;

    logic              accept, issue;
    logic              out_valid_d, out_valid_q;
    logic              out_load;
    logic [DATA_W-1:0] out_d_data;
    exc_t              out_d_exc;
    exc_t              out_q_exc;
    exc_t              acc_bundle;
    logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;

    // Merge the exception bundle of the incoming entry; the no-exception code is parametric.
    always_comb begin
        acc_bundle = exc_merge('{exc: in_exc, exccode: in_exccode, badvaddr: in_badvaddr},
                               '{exc: loc_exc, exccode: loc_exccode, badvaddr: loc_badvaddr});
        if (!acc_bundle.exc) begin
            acc_bundle.exccode = EXC_NONE;
        end
    end

    assign accept = in_valid && in_ready;
    assign issue  = out_valid_q && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_d, skid_valid_q;
    logic              skid_load;
    logic              out_from_skid;
    logic [DATA_W-1:0] skid_data;
    exc_t              skid_exc;

    // in_ready comes straight from a flop, breaking the out_ready -> in_ready path.
    assign in_ready = !skid_valid_q;

    // Steering: a held skid entry drains first; a stalled output diverts accepts to the skid.
    always_comb begin
        skid_valid_d  = skid_valid_q;
        out_valid_d   = out_valid_q;
        skid_load     = 1'b0;
        out_load      = 1'b0;
        out_from_skid = 1'b0;
        if (flush) begin
            skid_valid_d = 1'b0;
            out_valid_d  = 1'b0;
        end else if (skid_valid_q) begin
            if (out_ready) begin
                out_load      = 1'b1;
                out_from_skid = 1'b1;
                skid_valid_d  = 1'b0;
            end
        end else if (accept) begin
            if (out_valid_q && !out_ready) begin
                skid_load    = 1'b1;
                skid_valid_d = 1'b1;
            end else begin
                out_load    = 1'b1;
                out_valid_d = 1'b1;
            end
        end else if (issue) begin
            out_valid_d = 1'b0;
        end
    end

    // Skid occupancy flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_valid_q <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
        end
    end

    pipe_stage_slot #(
        .DATA_W    (DATA_W),
        .FLUSH_VAL (FLUSH_VAL),
        .NONE_CODE (EXC_NONE)
    ) u_skid_slot (
        .clk    (clk),
        .rst    (rst),
        .clear  (flush),
        .load   (skid_load),
        .d_data (in_data),
        .d_exc  (acc_bundle),
        .q_data (skid_data),
        .q_exc  (skid_exc)
    );

    assign out_d_data = out_from_skid ? skid_data : in_data;
    assign out_d_exc  = out_from_skid ? skid_exc  : acc_bundle;
`else
    assign in_ready = !out_valid_q || out_ready;

    // Single entry: accept (possibly with a same-cycle issue) refills, lone issue empties.
    always_comb begin
        out_valid_d = out_valid_q;
        out_load    = 1'b0;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_load    = 1'b1;
            out_valid_d = 1'b1;
        end else if (issue) begin
            out_valid_d = 1'b0;
        end
    end

    assign out_d_data = in_data;
    assign out_d_exc  = acc_bundle;
`endif

    // Output valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end

    pipe_stage_slot #(
        .DATA_W    (DATA_W),
        .FLUSH_VAL (FLUSH_VAL),
        .NONE_CODE (EXC_NONE)
    ) u_out_slot (
        .clk    (clk),
        .rst    (rst),
        .clear  (flush),
        .load   (out_load),
        .d_data (out_d_data),
        .d_exc  (out_d_exc),
        .q_data (out_data),
        .q_exc  (out_q_exc)
    );

    // Stall counter: counts blocked-output cycles, saturates, survives flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_exc      = out_q_exc.exc;
    assign out_exccode  = out_q_exc.exccode;
    assign out_badvaddr = out_q_exc.badvaddr;
    assign stall_cnt    = stall_cnt_q;

    // A blocked output must hold its entry until it is taken or flushed.
    a_out_stable : assert property (@(posedge clk) disable iff (!rst)
        (out_valid_q && !out_ready && !flush) |=>
        (out_valid_q && $stable(out_data) && $stable(out_q_exc)));

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic (default and PIPE_STAGE_SKID_EN builds).
module tb_pipe_stage_elastic;

    typedef struct packed {
        logic [63:0] data;
        logic        exc;
        logic [4:0]  code;
        logic [31:0] bva;
    } sb_t;

    typedef struct {
        logic        in_exc;
        logic [4:0]  in_code;
        logic [31:0] in_bva;
        logic        loc_exc;
        logic [4:0]  loc_code;
        logic [31:0] loc_bva;
        logic        exp_exc;
        logic [4:0]  exp_code;
        logic [31:0] exp_bva;
    } exc_vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        in_exc = 1'b0;
    logic [4:0]  in_exccode = '0;
    logic [31:0] in_badvaddr = '0;
    logic        loc_exc = 1'b0;
    logic [4:0]  loc_exccode = '0;
    logic [31:0] loc_badvaddr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        out_exc;
    logic [4:0]  out_exccode;
    logic [31:0] out_badvaddr;
    logic [15:0] stall_cnt;

    // Second instance for counter saturation with CNT_W=4.
    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [7:0]  in_data2 = 8'h3c;
    logic        out_valid2;
    logic [7:0]  out_data2;
    logic        out_exc2;
    logic [4:0]  out_exccode2;
    logic [31:0] out_badvaddr2;
    logic [3:0]  stall_cnt2;
    logic        zero1 = 1'b0;
    logic [4:0]  zero5 = '0;
    logic [31:0] zero32 = '0;

    int checks = 0;
    int errors = 0;
    bit sb_en = 1'b0;
    int pops = 0;
    sb_t sb_q[$];
    exc_vec_t vecs[4];

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(64), .CNT_W(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_exc       (in_exc),
        .in_exccode   (in_exccode),
        .in_badvaddr  (in_badvaddr),
        .loc_exc      (loc_exc),
        .loc_exccode  (loc_exccode),
        .loc_badvaddr (loc_badvaddr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_exc      (out_exc),
        .out_exccode  (out_exccode),
        .out_badvaddr (out_badvaddr),
        .stall_cnt    (stall_cnt)
    );

    pipe_stage_elastic #(.DATA_W(8), .CNT_W(4)) u_sat (
        .clk          (clk),
        .rst          (rst),
        .flush        (zero1),
        .in_valid     (in_valid2),
        .in_ready     (in_ready2),
        .in_data      (in_data2),
        .in_exc       (zero1),
        .in_exccode   (zero5),
        .in_badvaddr  (zero32),
        .loc_exc      (zero1),
        .loc_exccode  (zero5),
        .loc_badvaddr (zero32),
        .out_valid    (out_valid2),
        .out_ready    (zero1),
        .out_data     (out_data2),
        .out_exc      (out_exc2),
        .out_exccode  (out_exccode2),
        .out_badvaddr (out_badvaddr2),
        .stall_cnt    (stall_cnt2)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference merge: upstream wins, then local, else the no-exception image.
    function automatic sb_t model(input logic [63:0] d, input logic ie, input logic [4:0] ic,
                                  input logic [31:0] ib, input logic le, input logic [4:0] lc,
                                  input logic [31:0] lb);
        sb_t r;
        r.data = d;
        if (ie) begin
            r.exc = 1'b1; r.code = ic; r.bva = ib;
        end else if (le) begin
            r.exc = 1'b1; r.code = lc; r.bva = lb;
        end else begin
            r.exc = 1'b0; r.code = 5'd15; r.bva = 32'h0;
        end
        return r;
    endfunction

    // Scoreboard: push on accept, pop and compare on issue.
    always @(negedge clk) begin
        if (rst && sb_en) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got data 0x%0h expected no entry", out_data);
                end else begin
                    sb_t exp_e;
                    sb_t act_e;
                    exp_e = sb_q.pop_front();
                    act_e = '{data: out_data, exc: out_exc, code: out_exccode, bva: out_badvaddr};
                    pops++;
                    chk("sb_entry", 128'(act_e), 128'(exp_e));
                end
            end
            if (in_valid && in_ready && !flush) begin
                sb_q.push_back(model(in_data, in_exc, in_exccode, in_badvaddr,
                                     loc_exc, loc_exccode, loc_badvaddr));
            end
        end
    end

    initial begin
        int bubbles;
        int rdy_seen;
        bit sent;
        logic [15:0] stall_before;

        vecs[0] = '{1'b1, 5'd4, 32'h1000, 1'b1, 5'd12, 32'h2002, 1'b1, 5'd4, 32'h1000};
        vecs[1] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h2002, 1'b1, 5'd12, 32'h2002};
        vecs[2] = '{1'b0, 5'd4, 32'h1234, 1'b0, 5'd12, 32'h5678, 1'b0, 5'd15, 32'h0};
        vecs[3] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h3003, 1'b1, 5'd5, 32'h3003};

        // Reset state
        #12;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk("rst_out_exc", 128'(out_exc), 128'(0));
        chk("rst_out_exccode", 128'(out_exccode), 128'(15));
        chk("rst_out_badvaddr", 128'(out_badvaddr), 128'(0));
        chk("rst_stall_cnt", 128'(stall_cnt), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_sat_stall", 128'(stall_cnt2), 128'(0));
        rst = 1'b1;
        sb_en = 1'b1;

        // 1. Back-to-back stream
        out_ready = 1'b1;
        bubbles = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data = 64'(i);
            @(negedge clk);
            if (i > 0 && !out_valid) bubbles++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        chk("stream_pops", 128'(pops), 128'(100));
        chk("stream_bubbles", 128'(bubbles), 128'(0));
        chk("stream_stall_cnt", 128'(stall_cnt), 128'(0));
        chk("stream_drained", 128'(sb_q.size()), 128'(0));

        // 2. Backpressure
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 64'ha5;
        sent = 1'b0;
        rdy_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            in_valid = !sent;
            in_data = 64'h5a;
            @(negedge clk);
            chk("bp_hold_data", 128'(out_data), 128'(64'ha5));
            chk("bp_hold_valid", 128'(out_valid), 128'(1));
            if (in_ready) rdy_seen++;
            if (in_valid && in_ready) sent = 1'b1;
        end
        @(posedge clk); #1;
        chk("bp_stall_cnt", 128'(stall_cnt), 128'(5));
`ifdef PIPE_STAGE_SKID_EN
        chk("bp_skid_took_one", 128'(sent), 128'(1));
        chk("bp_skid_ready_times", 128'(rdy_seen), 128'(1));
`else
        chk("bp_ready_low", 128'(rdy_seen), 128'(0));
`endif
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = !sent;
            in_data = 64'h5a;
            @(negedge clk);
            if (in_valid && in_ready) sent = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_drained", 128'(sb_q.size()), 128'(0));
        chk("bp_stall_after", 128'(stall_cnt), 128'(5));

        // 3. Exception merge vectors
        for (int v = 0; v < 4; v++) begin
            in_valid = 1'b1;
            in_data = 64'(100 + v);
            in_exc = vecs[v].in_exc;
            in_exccode = vecs[v].in_code;
            in_badvaddr = vecs[v].in_bva;
            loc_exc = vecs[v].loc_exc;
            loc_exccode = vecs[v].loc_code;
            loc_badvaddr = vecs[v].loc_bva;
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_exc = 1'b0;
            loc_exc = 1'b0;
            @(negedge clk);
            chk("exc_valid", 128'(out_valid), 128'(1));
            chk("exc_flag", 128'(out_exc), 128'(vecs[v].exp_exc));
            chk("exc_code", 128'(out_exccode), 128'(vecs[v].exp_code));
            chk("exc_badvaddr", 128'(out_badvaddr), 128'(vecs[v].exp_bva));
            @(posedge clk); #1;
        end

        // 4. Flush while full, with a competing input
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 64'h11;
        in_exc = 1'b1;
        in_exccode = 5'd4;
        in_badvaddr = 32'h1000;
        @(posedge clk); #1;
        in_data = 64'h22;
        in_exc = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        in_data = 64'h33;
        @(negedge clk);
        stall_before = stall_cnt;
        chk("fl_full_valid", 128'(out_valid), 128'(1));
        chk("fl_full_exc", 128'(out_exc), 128'(1));
`ifdef PIPE_STAGE_SKID_EN
        chk("fl_skid_full", 128'(in_ready), 128'(0));
`endif
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 128'(out_valid), 128'(0));
        chk("fl_out_data", 128'(out_data), 128'(0));
        chk("fl_out_exc", 128'(out_exc), 128'(0));
        chk("fl_out_exccode", 128'(out_exccode), 128'(15));
        chk("fl_stall_kept", 128'(stall_cnt), 128'(stall_before));
        chk("fl_in_ready", 128'(in_ready), 128'(1));
        sb_q.delete();
        @(posedge clk); #1;
        chk("fl_no_capture", 128'(out_valid), 128'(0));
        chk("fl_stall_idle", 128'(stall_cnt), 128'(stall_before));

        // 5. Asynchronous reset mid-cycle
        in_valid = 1'b1;
        in_data = 64'h77;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("ar_before_valid", 128'(out_valid), 128'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("ar_out_valid", 128'(out_valid), 128'(0));
        chk("ar_out_data", 128'(out_data), 128'(0));
        chk("ar_out_exccode", 128'(out_exccode), 128'(15));
        chk("ar_stall_cnt", 128'(stall_cnt), 128'(0));
        sb_q.delete();
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data = 64'h88;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("ar_after_valid", 128'(out_valid), 128'(1));
        chk("ar_after_data", 128'(out_data), 128'(64'h88));
        @(posedge clk); #1;
        chk("ar_drained", 128'(sb_q.size()), 128'(0));

        // 6. Stall counter saturation, CNT_W=4
        in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("sat_14", 128'(stall_cnt2), 128'(14));
        repeat (6) @(posedge clk);
        #1;
        chk("sat_20", 128'(stall_cnt2), 128'(15));
        chk("sat_hold_data", 128'(out_data2), 128'(8'h3c));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
